siso_trellis_ctrl: RTL and testbench

- Sequencer for one max-log-MAP SISO decoder instance.
- Drives the trellis-phase code (fsm_state) and the valid_branch strobe shared by the alpha (forward) and beta (backward) recursion units.
- Generates addresses for the branch-metric buffer and for the alpha state-metric memory.
- Runs one forward pass, then one backward pass, per block of blk_len trellis steps.

---
 rtl/siso_trellis_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_siso_trellis_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siso_trellis_ctrl.sv
// siso_trellis_ctrl: sequencer for one max-log-MAP SISO decoder.
// Runs a forward (alpha) pass and then a backward (beta) pass over a block
// of len_q trellis steps. Each step is a compute cycle followed by a commit
// cycle. The block also drives the branch-metric buffer and the alpha
// memory addresses that the recursion units use.
module siso_trellis_ctrl #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] blk_len,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic [1:0]        fsm_state,
    output logic              valid_branch,
    output logic              beta_init,
    output logic              br_rd_en,
    output logic [ADDR_W-1:0] br_rd_addr,
    output logic              alpha_wr_en,
    output logic [ADDR_W-1:0] alpha_wr_addr,
    output logic              alpha_rd_en,
    output logic [ADDR_W-1:0] alpha_rd_addr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_FWD  = 2'b01,
        S_BWD  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // Sub-phase inside a pass: prologue read, compute, commit, and the
    // forward-only tail cycle that writes the last alpha vector.
    typedef enum logic [1:0] {
        P_PRE  = 2'b00,
        P_COMP = 2'b01,
        P_COMM = 2'b10,
        P_TAIL = 2'b11
    } phase_t;

    state_t            state, state_n;
    phase_t            phase, phase_n;
    logic [ADDR_W-1:0] step, step_n;
    logic [ADDR_W-1:0] len_q, len_n;
    logic              len_err_q, len_err_n;
    logic [ADDR_W-1:0] br_addr_q, aw_addr_q, ar_addr_q;
    logic [ADDR_W-1:0] len_m1;

    // The step counter is compared against len_q-1 so it never needs to
    // count past the block length, even for the largest block.
    assign len_m1    = len_q - ADDR_W'(1);
    assign fsm_state = state;
    assign len_err   = len_err_q;

    // State, counters and held addresses; addresses re-register whatever the
    // output shows so they keep their last value while the enable is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            phase     <= P_PRE;
            step      <= '0;
            len_q     <= '0;
            len_err_q <= 1'b0;
            br_addr_q <= '0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            step      <= step_n;
            len_q     <= len_n;
            len_err_q <= len_err_n;
            br_addr_q <= br_rd_addr;
            aw_addr_q <= alpha_wr_addr;
            ar_addr_q <= alpha_rd_addr;
        end
    end

    // Next-state sequencing and all strobes/addresses for the current cycle.
    always_comb begin
        state_n       = state;
        phase_n       = phase;
        step_n        = step;
        len_n         = len_q;
        len_err_n     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        valid_branch  = 1'b0;
        beta_init     = 1'b0;
        br_rd_en      = 1'b0;
        br_rd_addr    = br_addr_q;
        alpha_wr_en   = 1'b0;
        alpha_wr_addr = aw_addr_q;
        alpha_rd_en   = 1'b0;
        alpha_rd_addr = ar_addr_q;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (blk_len != '0) begin
                        len_n   = blk_len;
                        state_n = S_FWD;
                        phase_n = P_PRE;
                        step_n  = '0;
                    end else begin
                        len_err_n = 1'b1;
                    end
                end
            end

            S_FWD: begin
                busy = 1'b1;
                case (phase)
                    P_PRE: begin
                        br_rd_en   = 1'b1;
                        br_rd_addr = '0;
                        step_n     = '0;
                        phase_n    = P_COMP;
                    end
                    P_COMP: begin
                        valid_branch = 1'b1;
                        // The previous step's alpha is still on the unit outputs.
                        if (step != '0) begin
                            alpha_wr_en   = 1'b1;
                            alpha_wr_addr = step - ADDR_W'(1);
                        end
                        phase_n = P_COMM;
                    end
                    P_COMM: begin
                        if (step != len_m1) begin
                            br_rd_en   = 1'b1;
                            br_rd_addr = step + ADDR_W'(1);
                            step_n     = step + ADDR_W'(1);
                            phase_n    = P_COMP;
                        end else begin
                            phase_n = P_TAIL;
                        end
                    end
                    P_TAIL: begin
                        alpha_wr_en   = 1'b1;
                        alpha_wr_addr = step;
                        state_n       = S_BWD;
                        phase_n       = P_PRE;
                    end
                    default: phase_n = P_PRE;
                endcase
            end

            S_BWD: begin
                busy = 1'b1;
                case (phase)
                    P_PRE: begin
                        beta_init  = 1'b1;
                        br_rd_en   = 1'b1;
                        br_rd_addr = len_m1;
                        step_n     = len_m1;
                        phase_n    = P_COMP;
                    end
                    P_COMP: begin
                        valid_branch = 1'b1;
                        phase_n      = P_COMM;
                    end
                    P_COMM: begin
                        // Alpha read now so the data lines up with the next compute.
                        alpha_rd_en   = 1'b1;
                        alpha_rd_addr = step;
                        if (step != '0) begin
                            br_rd_en   = 1'b1;
                            br_rd_addr = step - ADDR_W'(1);
                            step_n     = step - ADDR_W'(1);
                            phase_n    = P_COMP;
                        end else begin
                            state_n = S_DONE;
                            phase_n = P_PRE;
                        end
                    end
                    default: phase_n = P_PRE;
                endcase
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = S_IDLE;
                phase_n = P_PRE;
            end

            default: begin
                state_n = S_IDLE;
                phase_n = P_PRE;
            end
        endcase
    end

endmodule

// File: tb/tb_siso_trellis_ctrl.sv
// tb_siso_trellis_ctrl: self-checking bench for siso_trellis_ctrl.
// A cycle-level reference model derives every output from the block's
// position relative to the first forward cycle; a table of per-block
// totals and a few directed sequences cover the multi-cycle corners.
module tb_siso_trellis_ctrl;

    localparam int W = 13;

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         len_err;
        logic [1:0]   fsm;
        logic         vb;
        logic         bi;
        logic         bre;
        logic [W-1:0] bra;
        logic         awe;
        logic [W-1:0] awa;
        logic         are;
        logic [W-1:0] ara;
    } outs_t;

    typedef struct {
        int len;
        int doneOff;
        int vbCnt;
        int brCnt;
        int awCnt;
        int arCnt;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] blk_len;
    logic         busy, done, len_err, valid_branch, beta_init;
    logic [1:0]   fsm_state;
    logic         br_rd_en, alpha_wr_en, alpha_rd_en;
    logic [W-1:0] br_rd_addr, alpha_wr_addr, alpha_rd_addr;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit checkEn = 0;

    // reference model state
    bit           mActive = 0;
    int           mT = 0;
    int           mLen = 0;
    bit           mLenErr = 0;
    logic [W-1:0] mBr = '0, mAw = '0, mAr = '0;

    // observed statistics
    int vbCnt, brCnt, awCnt, arCnt, doneCnt, lenErrCnt, busyCnt, biCnt;
    int fwdEntryCyc, doneCyc;
    logic [1:0] prevFsm = 2'b00;
    logic prevVb = 1'b0;

    siso_trellis_ctrl #(.ADDR_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .blk_len(blk_len),
        .busy(busy), .done(done), .len_err(len_err), .fsm_state(fsm_state),
        .valid_branch(valid_branch), .beta_init(beta_init),
        .br_rd_en(br_rd_en), .br_rd_addr(br_rd_addr),
        .alpha_wr_en(alpha_wr_en), .alpha_wr_addr(alpha_wr_addr),
        .alpha_rd_en(alpha_rd_en), .alpha_rd_addr(alpha_rd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t actualOut();
        outs_t a;
        a.busy = busy; a.done = done; a.len_err = len_err; a.fsm = fsm_state;
        a.vb = valid_branch; a.bi = beta_init;
        a.bre = br_rd_en; a.bra = br_rd_addr;
        a.awe = alpha_wr_en; a.awa = alpha_wr_addr;
        a.are = alpha_rd_en; a.ara = alpha_rd_addr;
        return a;
    endfunction

    // Expected outputs from the offset mT since the first forward cycle:
    // forward lasts 2L+2 cycles, backward 2L+1, then one DONE cycle.
    function automatic outs_t modelOut();
        outs_t e;
        int o2, m;
        e = '0;
        e.len_err = mLenErr;
        e.bra = mBr; e.awa = mAw; e.ara = mAr;
        if (mActive) begin
            e.busy = 1'b1;
            if (mT < 2*mLen+2) begin
                e.fsm = 2'b01;
                if (mT == 0) begin
                    e.bre = 1'b1; e.bra = '0;
                end else if (mT % 2 == 0 && (mT-2)/2 + 1 < mLen) begin
                    e.bre = 1'b1; e.bra = W'((mT-2)/2 + 1);
                end
                if (mT % 2 == 1 && mT <= 2*mLen-1) e.vb = 1'b1;
                if (mT % 2 == 1 && mT >= 3) begin
                    e.awe = 1'b1; e.awa = W'((mT-3)/2);
                end
            end else if (mT < 4*mLen+3) begin
                o2 = mT - (2*mLen+2);
                e.fsm = 2'b10;
                if (o2 == 0) begin
                    e.bi = 1'b1; e.bre = 1'b1; e.bra = W'(mLen-1);
                end else if (o2 % 2 == 1) begin
                    e.vb = 1'b1;
                end else begin
                    m = mLen - 1 - (o2-2)/2;
                    e.are = 1'b1; e.ara = W'(m);
                    if (m > 0) begin
                        e.bre = 1'b1; e.bra = W'(m-1);
                    end
                end
            end else begin
                e.fsm = 2'b11;
                e.done = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic advanceModel(input logic r, input logic s, input logic [W-1:0] l);
        outs_t e;
        e = modelOut();
        if (r) begin
            mActive = 0; mLenErr = 0; mBr = '0; mAw = '0; mAr = '0;
            checkEn = 1;
        end else begin
            mBr = e.bra; mAw = e.awa; mAr = e.ara;
            mLenErr = !mActive && s && (l == '0);
            if (mActive) begin
                mT++;
                if (mT == 4*mLen+4) mActive = 0;
            end else if (s && l != '0) begin
                mActive = 1; mT = 0; mLen = int'(l);
            end
        end
    endtask

    task automatic checkOutput();
        outs_t a, e;
        a = actualOut();
        if (checkEn) begin
            e = modelOut();
            tests++;
            if (a !== e) begin
                fails++;
                $display("[TB] FAIL model_cycle cyc=%0d actual=%h required=%h", cyc, a, e);
            end
            if (a.vb) begin
                tests++;
                if (prevVb) begin
                    fails++;
                    $display("[TB] FAIL vb_back_to_back cyc=%0d actual=1 required=0", cyc);
                end
            end
            if (a.vb) vbCnt++;
            if (a.bre) brCnt++;
            if (a.awe) awCnt++;
            if (a.are) arCnt++;
            if (a.bi) biCnt++;
            if (a.done) begin doneCnt++; doneCyc = cyc; end
            if (a.len_err) lenErrCnt++;
            if (a.busy) busyCnt++;
            if (a.fsm == 2'b01 && prevFsm != 2'b01) fwdEntryCyc = cyc;
            prevFsm = a.fsm;
            prevVb = a.vb;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [W-1:0] l);
        rst = r; start = s; blk_len = l;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        advanceModel(r, s, l);
        cyc++;
        #1;
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clearStats();
        vbCnt = 0; brCnt = 0; awCnt = 0; arCnt = 0; biCnt = 0;
        doneCnt = 0; lenErrCnt = 0; busyCnt = 0;
        fwdEntryCyc = -1; doneCyc = -1;
    endtask

    // Start a block and clock until the model says it has ended; with noise,
    // extra start pulses (random lengths, including 0) arrive while busy.
    task automatic runBlock(input int len, input bit noise);
        int guard;
        applyStimulus(1'b0, 1'b1, W'(len));
        guard = 0;
        while (mActive && guard < 4*len+16) begin
            applyStimulus(1'b0, noise && ($urandom_range(0, 3) == 0),
                          noise ? W'($urandom_range(0, 40)) : '0);
            guard++;
        end
        tests++;
        if (mActive) begin
            fails++;
            $display("[TB] FAIL block_timeout len=%0d actual=running required=ended", len);
        end
    endtask

    initial begin
        vec_t vecs[4];
        rst = 1'b1; start = 1'b0; blk_len = '0;
        clearStats();

        // reset, then a quiet idle stretch
        repeat (3) applyStimulus(1'b1, 1'b0, '0);
        clearStats();
        repeat (10) applyStimulus(1'b0, 1'b0, '0);
        checkVal("idle_vb", vbCnt, 0);
        checkVal("idle_busy", busyCnt, 0);

        // per-block totals: done offset 4L+3, 2L strobes, L alpha accesses
        vecs[0] = '{1, 7, 2, 2, 1, 1};
        vecs[1] = '{2, 11, 4, 4, 2, 2};
        vecs[2] = '{4, 19, 8, 8, 4, 4};
        vecs[3] = '{7, 31, 14, 14, 7, 7};
        foreach (vecs[i]) begin
            clearStats();
            runBlock(vecs[i].len, 1'b0);
            applyStimulus(1'b0, 1'b0, '0);
            checkVal($sformatf("done_off_L%0d", vecs[i].len), doneCyc - fwdEntryCyc, vecs[i].doneOff);
            checkVal($sformatf("vb_cnt_L%0d", vecs[i].len), vbCnt, vecs[i].vbCnt);
            checkVal($sformatf("br_cnt_L%0d", vecs[i].len), brCnt, vecs[i].brCnt);
            checkVal($sformatf("aw_cnt_L%0d", vecs[i].len), awCnt, vecs[i].awCnt);
            checkVal($sformatf("ar_cnt_L%0d", vecs[i].len), arCnt, vecs[i].arCnt);
            checkVal($sformatf("bi_cnt_L%0d", vecs[i].len), biCnt, 1);
            checkVal($sformatf("done_cnt_L%0d", vecs[i].len), doneCnt, 1);
        end

        // zero-length request
        clearStats();
        applyStimulus(1'b0, 1'b1, '0);
        repeat (4) applyStimulus(1'b0, 1'b0, '0);
        checkVal("len_err_cnt", lenErrCnt, 1);
        checkVal("len_err_busy", busyCnt, 0);

        // starts while busy are ignored; back-to-back restart after DONE
        clearStats();
        runBlock(6, 1'b1);
        runBlock(3, 1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        checkVal("busy_start_done_cnt", doneCnt, 2);
        checkVal("busy_start_len_err", lenErrCnt, 0);

        // reset during forward step 2 of an 8-step block
        clearStats();
        applyStimulus(1'b0, 1'b1, W'(8));
        repeat (5) applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0);
        tests++;
        if (actualOut() !== outs_t'('0)) begin
            fails++;
            $display("[TB] FAIL abort_outputs actual=%h required=0", actualOut());
        end
        checkVal("abort_done_cnt", doneCnt, 0);
        runBlock(3, 1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        checkVal("after_abort_done_cnt", doneCnt, 1);

        // randomized blocks, gaps and noise against the model
        repeat (30) begin
            repeat ($urandom_range(0, 3))
                applyStimulus(1'b0, $urandom_range(0, 5) == 0, '0);
            runBlock($urandom_range(1, 24), 1'b1);
        end

        // largest block: counter must reach 2^W-2 without wrapping
        clearStats();
        runBlock((1 << W) - 1, 1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        checkVal("max_done_off", doneCyc - fwdEntryCyc, 4*((1 << W) - 1) + 3);
        checkVal("max_vb_cnt", vbCnt, 2*((1 << W) - 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
